// File: rtl/toggle_sched_pkg.sv
// Shared types and helpers for the periodic-inversion controller.
package toggle_sched_pkg;

  localparam int WIDTH_DEF    = 4;
  localparam int PERIOD_W_DEF = 8;
  localparam int COUNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A zero period behaves as one cycle so the sequence can never stall.
  function automatic logic [31:0] eff_period(input logic [31:0] p);
    return (p == 32'd0) ? 32'd1 : p;
  endfunction

endpackage

// File: rtl/toggle_sched_timer.sv
// Reloadable down-counter: expire_o flags zero; an enabled expiry reloads.
module toggle_sched_timer
  import toggle_sched_pkg::*;
#(
  parameter int W = PERIOD_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = reload_i;
    end else if (en_i) begin
      cnt_d = expire_o ? reload_i : (cnt_q - W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/toggle_sched_ctrl.sv
// Periodic-inversion controller; define TOGGLE_SCHED_PAUSE_EN to add a pause input.
module toggle_sched_ctrl
  import toggle_sched_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [COUNT_W-1:0]  num_toggles,
  input  logic [WIDTH-1:0]    init_val,
`ifdef TOGGLE_SCHED_PAUSE_EN
  input  logic                pause,
`endif
  output logic [WIDTH-1:0]    value,
  output logic                toggle_pulse,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  toggles_done
);

  state_e                state_q;
  logic [WIDTH-1:0]      value_q;
  logic                  pulse_q;
  logic                  busy_q;
  logic                  done_q;
  logic [COUNT_W-1:0]    tog_q;
  logic [PERIOD_W-1:0]   period_q;
  logic [COUNT_W-1:0]    num_q;

  logic                  pause_w;
  logic                  load;
  logic                  run_en;
  logic                  expire;
  logic                  fire;
  logic [PERIOD_W-1:0]   reload_val;
  logic [COUNT_W-1:0]    tog_inc;
  logic                  last;

`ifdef TOGGLE_SCHED_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign load       = (state_q == S_IDLE) && start;
  // On the accepting edge the fresh period is not latched yet, so use the port.
  assign reload_val = PERIOD_W'(eff_period(32'(load ? period : period_q)) - 32'd1);
  assign run_en     = (state_q == S_RUN) && !stop && !pause_w;
  assign fire       = run_en && expire;
  assign tog_inc    = tog_q + COUNT_W'(1);
  assign last       = (num_q != '0) && (tog_inc == num_q);

  toggle_sched_timer #(
    .W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .en_i     (run_en),
    .reload_i (reload_val),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      value_q  <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tog_q    <= '0;
      period_q <= '0;
      num_q    <= '0;
    end else begin
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            value_q  <= init_val;
            tog_q    <= '0;
            period_q <= period;
            num_q    <= num_toggles;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort wins over a coinciding expiry.
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (fire) begin
            value_q <= ~value_q;
            pulse_q <= 1'b1;
            tog_q   <= tog_inc;
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign value        = value_q;
  assign toggle_pulse = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign toggles_done = tog_q;

endmodule

// File: tb/tb_toggle_sched_ctrl.sv
// Bench for toggle_sched_ctrl: directed and random sequences against an elapsed-time model.
module tb_toggle_sched_ctrl;

  localparam int WIDTH    = 4;
  localparam int PERIOD_W = 8;
  localparam int COUNT_W  = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] period;
  logic [COUNT_W-1:0]  num_toggles;
  logic [WIDTH-1:0]    init_val;
  logic [WIDTH-1:0]    value;
  logic                toggle_pulse;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  toggles_done;

  toggle_sched_ctrl #(
    .WIDTH    (WIDTH),
    .PERIOD_W (PERIOD_W),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .period       (period),
    .num_toggles  (num_toggles),
    .init_val     (init_val),
`ifdef TOGGLE_SCHED_PAUSE_EN
    .pause        (1'b0),
`endif
    .value        (value),
    .toggle_pulse (toggle_pulse),
    .busy         (busy),
    .done         (done),
    .toggles_done (toggles_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: a sequence started at edge k has performed floor(e/P) inversions
  // after e further edges, capped at N when bounded.
  int               cyc = 0;
  int               k = 0;
  int               Pe = 1;
  int               Ne = 0;
  bit               m_run = 1'b0;
  logic [WIDTH-1:0] ini = '0;
  logic [WIDTH-1:0] f_val = '0;
  int               f_tog = 0;
  logic [WIDTH-1:0] e_val;
  int               e_tog;
  bit               e_busy, e_done, e_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    chk("value", 32'(value), 32'(e_val));
    chk("toggles_done", 32'(toggles_done), 32'(e_tog));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("toggle_pulse", 32'(toggle_pulse), 32'(e_pulse));
  endtask

  function automatic logic [WIDTH-1:0] val_after(input int inv);
    return (inv % 2 == 1) ? ~ini : ini;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    f_val = '0;
    f_tog = 0;
    e_val = '0; e_tog = 0; e_busy = 0; e_done = 0; e_pulse = 0;
  endtask

  task automatic model_edge(input bit st, input bit sp);
    int e, inv;
    if (!m_run) begin
      if (st) begin
        k     = cyc;
        m_run = 1'b1;
        Pe    = (period == '0) ? 1 : int'(period);
        Ne    = int'(num_toggles);
        ini   = init_val;
      end
    end else begin
      e = cyc - k;
      if (sp && (Ne == 0 || e <= Ne * Pe)) begin
        inv   = (e - 1) / Pe;
        f_val = val_after(inv);
        f_tog = inv % (1 << COUNT_W);
        m_run = 1'b0;
      end else if (Ne != 0 && e > Ne * Pe) begin
        f_val = val_after(Ne);
        f_tog = Ne % (1 << COUNT_W);
        m_run = 1'b0;
      end
    end
    if (m_run) begin
      e   = cyc - k;
      inv = e / Pe;
      if (Ne != 0 && inv > Ne) inv = Ne;
      e_val   = val_after(inv);
      e_tog   = inv % (1 << COUNT_W);
      e_busy  = (Ne == 0) || (e < Ne * Pe);
      e_done  = (Ne != 0) && (e == Ne * Pe);
      e_pulse = (e > 0) && (e % Pe == 0) && (Ne == 0 || e <= Ne * Pe);
    end else begin
      e_val = f_val; e_tog = f_tog; e_busy = 0; e_done = 0; e_pulse = 0;
    end
  endtask

  task automatic tick(input bit st, input bit sp);
    start = st;
    stop  = sp;
    @(posedge clk);
    cyc++;
    model_edge(st, sp);
    #1;
    check_all();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic setup(input logic [WIDTH-1:0] iv, input int p, input int n);
    init_val    = iv;
    period      = PERIOD_W'(p);
    num_toggles = COUNT_W'(n);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    setup(4'h0, 1, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // Bounded run: 5 -> A at k+10 -> 5 at k+20, done after k+20.
    setup(4'h5, 10, 2);
    tick(1'b1, 1'b0);
    repeat (9) tick(1'b0, 1'b0);
    chk("bounded_pre", 32'(value), 32'h5);
    tick(1'b0, 1'b0);
    chk("bounded_first", 32'(value), 32'hA);
    repeat (10) tick(1'b0, 1'b0);
    chk("bounded_done", 32'(done), 32'd1);
    chk("bounded_count", 32'(toggles_done), 32'd2);
    repeat (3) tick(1'b0, 1'b0);

    // Zero period behaves as one cycle.
    setup(4'h0, 0, 3);
    tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);

    // Free-run wrap of the toggle count, then stop without done.
    setup(4'h0, 1, 0);
    tick(1'b1, 1'b0);
    repeat (256) tick(1'b0, 1'b0);
    chk("wrap_count", 32'(toggles_done), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd1);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);

    // Stop on the expiry edge.
    setup(4'h9, 4, 0);
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("collide_value", 32'(value), 32'h9);
    repeat (2) tick(1'b0, 1'b0);

    // Start while busy is ignored, including new fields.
    setup(4'h6, 3, 3);
    tick(1'b1, 1'b0);
    repeat (2) tick(1'b0, 1'b0);
    setup(4'h3, 1, 7);
    tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);

    // Start and stop together in idle: start wins.
    setup(4'hC, 2, 1);
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b0, 1'b0);

    // Asynchronous reset mid-run.
    setup(4'hB, 5, 0);
    tick(1'b1, 1'b0);
    repeat (7) tick(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b0);

    // Random sequences with stray start/stop pulses and changing fields.
    for (int s = 0; s < 10; s++) begin
      setup(4'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      tick(1'b1, 1'b0);
      for (int c = 0; c < 40; c++) begin
        setup(4'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
        tick($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      end
      tick(1'b0, 1'b1);
      repeat (2) tick(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
